// File: rtl/sdram_cache.sv
// Direct-mapped, write-through, no-write-allocate word cache between the CPU bus and the SDRAM controller.
// Define SDRAM_CACHE_FLUSH_EN to add the flush/flush_busy ports and the valid-bit flush engine.
module sdram_cache #(
  parameter int LINES = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [24:0] cpu_addr,
  input  logic [31:0] cpu_din,
  input  logic [3:0]  cpu_wmask,
  input  logic        cpu_valid,
  output logic [31:0] cpu_dout,
  output logic        cpu_ready,
`ifdef SDRAM_CACHE_FLUSH_EN
  input  logic        flush,
  output logic        flush_busy,
`endif
  output logic [24:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [3:0]  mem_wmask,
  output logic        mem_valid,
  input  logic [31:0] mem_dout,
  input  logic        mem_ready
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 23 - IW;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_RD,
    MEM_WR,
    RESP
`ifdef SDRAM_CACHE_FLUSH_EN
    , FLUSH
`endif
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [31:0]    data_mem [LINES];
  logic [TW-1:0]  tag_mem  [LINES];
  logic [LINES-1:0] valid_q;

  logic [24:0]    req_addr_q;
  logic [31:0]    req_din_q;
  logic [3:0]     req_wmask_q;
  logic [31:0]    rd_data_q;
  logic [TW-1:0]  rd_tag_q;
  logic           rd_valid_q;

  logic [31:0]    cpu_dout_q;
  logic           mem_valid_q;
  logic [24:0]    mem_addr_q;
  logic [31:0]    mem_din_q;
  logic [3:0]     mem_wmask_q;

  logic [IW-1:0]  idx_in;
  logic [IW-1:0]  req_idx;
  logic [TW-1:0]  req_tag;
  logic           is_wr;
  logic           hit;
  logic           rd_hit;
  logic           rd_miss;
  logic [31:0]    merged;
  logic           accept;
  logic           fill;
  logic           merge;
  logic           to_rd;
  logic           to_wr;
  logic           lk_hit;

`ifdef SDRAM_CACHE_FLUSH_EN
  localparam logic [IW-1:0] LAST = IW'(LINES - 1);
  logic [IW-1:0]  flush_cnt_q;
  logic           flush_clr;
`endif

  assign idx_in  = cpu_addr[2 +: IW];
  assign req_idx = req_addr_q[2 +: IW];
  assign req_tag = req_addr_q[24 -: TW];
  assign is_wr   = |req_wmask_q;
  assign hit     = rd_valid_q && (rd_tag_q == req_tag);
  assign rd_hit  = !is_wr && hit;
  assign rd_miss = !is_wr && !hit;

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = req_wmask_q[b] ? req_din_q[8*b +: 8]
                                        : rd_data_q[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    fill    = 1'b0;
    merge   = 1'b0;
    to_rd   = 1'b0;
    to_wr   = 1'b0;
    lk_hit  = 1'b0;
`ifdef SDRAM_CACHE_FLUSH_EN
    flush_clr = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef SDRAM_CACHE_FLUSH_EN
        if (flush) begin
          state_d = FLUSH;
        end else if (cpu_valid && !cpu_ready) begin
          accept  = 1'b1;
          state_d = LOOKUP;
        end
`else
        if (cpu_valid && !cpu_ready) begin
          accept  = 1'b1;
          state_d = LOOKUP;
        end
`endif
      end
      LOOKUP: begin
        unique case (1'b1)
          is_wr: begin
            to_wr   = 1'b1;
            state_d = MEM_WR;
          end
          rd_hit: begin
            lk_hit  = 1'b1;
            state_d = RESP;
          end
          rd_miss: begin
            to_rd   = 1'b1;
            state_d = MEM_RD;
          end
          default: state_d = IDLE;
        endcase
      end
      MEM_RD: begin
        if (mem_ready) begin
          fill    = 1'b1;
          state_d = RESP;
        end
      end
      MEM_WR: begin
        if (mem_ready) begin
          merge   = hit;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
`ifdef SDRAM_CACHE_FLUSH_EN
      FLUSH: begin
        flush_clr = 1'b1;
        if (flush_cnt_q == LAST) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Arrays carry no reset so they can map onto block RAM.
  always_ff @(posedge clk) begin
    if (fill || merge) begin
      data_mem[req_idx] <= fill ? mem_dout : merged;
      tag_mem[req_idx]  <= req_tag;
    end
    if (accept) begin
      req_addr_q  <= cpu_addr;
      req_din_q   <= cpu_din;
      req_wmask_q <= cpu_wmask;
      rd_data_q   <= data_mem[idx_in];
      rd_tag_q    <= tag_mem[idx_in];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q     <= '0;
      rd_valid_q  <= 1'b0;
      cpu_dout_q  <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_wmask_q <= '0;
`ifdef SDRAM_CACHE_FLUSH_EN
      flush_cnt_q <= '0;
`endif
    end else begin
      if (accept) rd_valid_q <= valid_q[idx_in];
      if (lk_hit) cpu_dout_q <= rd_data_q;
      if (to_rd) begin
        mem_valid_q <= 1'b1;
        mem_addr_q  <= req_addr_q;
        mem_wmask_q <= 4'b0000;
      end
      if (to_wr) begin
        mem_valid_q <= 1'b1;
        mem_addr_q  <= req_addr_q;
        mem_wmask_q <= req_wmask_q;
        mem_din_q   <= req_din_q;
      end
      if (fill) begin
        valid_q[req_idx] <= 1'b1;
        cpu_dout_q       <= mem_dout;
      end
      if (state_d == RESP && (state_q == MEM_RD || state_q == MEM_WR))
        mem_valid_q <= 1'b0;
`ifdef SDRAM_CACHE_FLUSH_EN
      if (flush_clr) begin
        valid_q[flush_cnt_q] <= 1'b0;
        flush_cnt_q          <= flush_cnt_q + 1'b1;
      end
`endif
    end
  end

  // Gate with mem_ready so the controller never sees valid in its ready cycle.
  assign mem_valid = mem_valid_q && !mem_ready;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_wmask = mem_wmask_q;
  assign cpu_dout  = cpu_dout_q;
  assign cpu_ready = (state_q == RESP);
`ifdef SDRAM_CACHE_FLUSH_EN
  assign flush_busy = (state_q == FLUSH);
`endif

endmodule

// File: tb/tb_sdram_cache.sv
// Directed self-checking bench for sdram_cache (LINES=64).
// Flush scenario compiled in only when SDRAM_CACHE_FLUSH_EN is defined.
module tb_sdram_cache;

  logic        clk = 1'b0;
  logic        resetn;
  logic [24:0] cpu_addr;
  logic [31:0] cpu_din;
  logic [3:0]  cpu_wmask;
  logic        cpu_valid;
  logic [31:0] cpu_dout;
  logic        cpu_ready;
  logic [24:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_wmask;
  logic        mem_valid;
  logic [31:0] mem_dout;
  logic        mem_ready;
`ifdef SDRAM_CACHE_FLUSH_EN
  logic        flush;
  logic        flush_busy;
`endif

  int checks   = 0;
  int failures = 0;

  int          r_txns;
  int          r_pulses;
  int          r_lat;
  int          r_vrbad;
  logic [31:0] r_dout;
  logic [24:0] r_maddr;
  logic [3:0]  r_mmask;
  logic [31:0] r_mdin;

  sdram_cache #(.LINES(64)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_wmask (cpu_wmask),
    .cpu_valid (cpu_valid),
    .cpu_dout  (cpu_dout),
    .cpu_ready (cpu_ready),
`ifdef SDRAM_CACHE_FLUSH_EN
    .flush     (flush),
    .flush_busy(flush_busy),
`endif
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_wmask (mem_wmask),
    .mem_valid (mem_valid),
    .mem_dout  (mem_dout),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One CPU request; a mem model answers each mem_valid after dly cycles.
  task automatic xact(input logic [24:0] a, input logic [31:0] d,
                      input logic [3:0] m, input logic [31:0] rdata,
                      input int dly);
    int  mcnt;
    bit  got;
    bit  prev_mv;
    r_txns = 0; r_pulses = 0; r_lat = -1; r_vrbad = 0;
    r_dout = '0; r_maddr = '0; r_mmask = '0; r_mdin = '0;
    mcnt = 0; got = 0; prev_mv = 0;
    @(negedge clk);
    cpu_addr = a; cpu_din = d; cpu_wmask = m; cpu_valid = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (mem_valid && mem_ready) r_vrbad++;
      if (mem_valid && !prev_mv) begin
        r_txns++;
        r_maddr = mem_addr; r_mmask = mem_wmask; r_mdin = mem_din;
      end
      prev_mv = mem_valid;
      if (cpu_ready) begin
        r_pulses++;
        if (!got) begin
          got = 1; r_lat = cyc; r_dout = cpu_dout;
        end
        cpu_valid = 1'b0;
      end
      if (cyc == 1) begin
        cpu_addr = a ^ 25'h155_5554;
        cpu_din  = ~d;
      end
      mem_ready = 1'b0;
      if (mem_valid) begin
        mcnt++;
        if (mcnt == dly) begin
          mem_ready = 1'b1; mem_dout = rdata; mcnt = 0;
        end
      end
      if (got && cyc >= r_lat + 3) break;
    end
    cpu_valid = 1'b0;
    mem_ready = 1'b0;
    chk("completed", {31'b0, got}, 32'd1);
  endtask

  initial begin
    int seen;
    resetn = 1'b0; cpu_addr = '0; cpu_din = '0; cpu_wmask = '0;
    cpu_valid = 1'b0; mem_dout = '0; mem_ready = 1'b0;
`ifdef SDRAM_CACHE_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst cpu_ready", {31'b0, cpu_ready}, 32'd0);
    chk("rst mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst cpu_dout", cpu_dout, 32'd0);
    chk("rst mem_addr", {7'b0, mem_addr}, 32'd0);
    chk("rst mem_din", mem_din, 32'd0);
    chk("rst mem_wmask", {28'b0, mem_wmask}, 32'd0);
`ifdef SDRAM_CACHE_FLUSH_EN
    chk("rst flush_busy", {31'b0, flush_busy}, 32'd0);
`endif
    resetn = 1'b1;

    xact(25'h100, 32'h0, 4'h0, 32'hDEADBEEF, 10);
    chk("miss1 txns", r_txns, 32'd1);
    chk("miss1 mmask", {28'b0, r_mmask}, 32'd0);
    chk("miss1 maddr", {7'b0, r_maddr}, 32'h100);
    chk("miss1 dout", r_dout, 32'hDEADBEEF);
    chk("miss1 pulses", r_pulses, 32'd1);
    chk("miss1 v&r", r_vrbad, 32'd0);

    xact(25'h100, 32'h0, 4'h0, 32'h0, 10);
    chk("hit1 txns", r_txns, 32'd0);
    chk("hit1 lat", r_lat, 32'd2);
    chk("hit1 dout", r_dout, 32'hDEADBEEF);
    chk("hit1 pulses", r_pulses, 32'd1);

    xact(25'h100, 32'h000000AA, 4'b0001, 32'h0, 3);
    chk("wr txns", r_txns, 32'd1);
    chk("wr mmask", {28'b0, r_mmask}, 32'h1);
    chk("wr mdin", r_mdin, 32'h000000AA);
    chk("wr maddr", {7'b0, r_maddr}, 32'h100);
    chk("wr pulses", r_pulses, 32'd1);
    chk("wr v&r", r_vrbad, 32'd0);

    xact(25'h100, 32'h0, 4'h0, 32'h0, 3);
    chk("merge txns", r_txns, 32'd0);
    chk("merge dout", r_dout, 32'hDEADBEAA);

    xact(25'h300, 32'h12345678, 4'hF, 32'h0, 2);
    chk("wmiss txns", r_txns, 32'd1);
    xact(25'h100, 32'h0, 4'h0, 32'h0, 2);
    chk("wmiss keep txns", r_txns, 32'd0);
    chk("wmiss keep dout", r_dout, 32'hDEADBEAA);

    xact(25'h200, 32'h0, 4'h0, 32'hCAFEF00D, 4);
    chk("conf txns", r_txns, 32'd1);
    chk("conf dout", r_dout, 32'hCAFEF00D);
    xact(25'h200, 32'h0, 4'h0, 32'h0, 4);
    chk("conf hit txns", r_txns, 32'd0);
    xact(25'h100, 32'h0, 4'h0, 32'h11112222, 4);
    chk("evict txns", r_txns, 32'd1);
    chk("evict dout", r_dout, 32'h11112222);

    xact(25'h104, 32'h0, 4'h0, 32'h55AA55AA, 1);
    chk("idx1 txns", r_txns, 32'd1);
    xact(25'h103, 32'h0, 4'h0, 32'h0, 1);
    chk("lowbits txns", r_txns, 32'd0);
    chk("lowbits dout", r_dout, 32'h11112222);

    xact(25'h0FC, 32'h0, 4'h0, 32'h0BADF00D, 5);
    chk("last miss txns", r_txns, 32'd1);
    xact(25'h0FC, 32'h0, 4'h0, 32'h0, 5);
    chk("last hit txns", r_txns, 32'd0);
    chk("last hit dout", r_dout, 32'h0BADF00D);

    // Stray mem_ready while idle must not disturb anything.
    @(negedge clk);
    mem_dout = 32'hFFFFFFFF; mem_ready = 1'b1;
    @(negedge clk);
    chk("stray ready", {31'b0, cpu_ready}, 32'd0);
    mem_ready = 1'b0;
    xact(25'h100, 32'h0, 4'h0, 32'h0, 2);
    chk("stray txns", r_txns, 32'd0);
    chk("stray dout", r_dout, 32'h11112222);

    xact(25'h104, 32'h11223344, 4'b1010, 32'h0, 2);
    chk("wr2 mmask", {28'b0, r_mmask}, 32'hA);
    xact(25'h104, 32'h0, 4'h0, 32'h0, 2);
    chk("wr2 dout", r_dout, 32'h11AA33AA);

    // Reset while waiting in MEM_RD.
    @(negedge clk);
    cpu_addr = 25'h200; cpu_wmask = 4'h0; cpu_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (mem_valid) seen = 1;
    end
    chk("rstop reached", seen, 32'd1);
    resetn = 1'b0; cpu_valid = 1'b0;
    @(negedge clk);
    chk("rstop mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rstop cpu_ready", {31'b0, cpu_ready}, 32'd0);
    chk("rstop mem_addr", {7'b0, mem_addr}, 32'd0);
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cpu_ready) seen++;
    end
    chk("rstop no pulse", seen, 32'd0);
    xact(25'h100, 32'h0, 4'h0, 32'h77778888, 3);
    chk("rstop refill txns", r_txns, 32'd1);
    chk("rstop refill dout", r_dout, 32'h77778888);

`ifdef SDRAM_CACHE_FLUSH_EN
    xact(25'h100, 32'h0, 4'h0, 32'h0, 3);
    chk("pre-flush hit", r_txns, 32'd0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    cpu_addr = 25'h100; cpu_wmask = 4'h0; cpu_valid = 1'b1;
    seen = 0;
    begin
      int rdy;
      rdy = 0;
      for (int i = 0; i < 200 && flush_busy; i++) begin
        seen++;
        if (cpu_ready || mem_valid) rdy++;
        @(negedge clk);
      end
      chk("flush busy cycles", seen, 32'd64);
      chk("flush no accept", rdy, 32'd0);
    end
    xact(25'h100, 32'h0, 4'h0, 32'h13579BDF, 3);
    chk("post-flush txns", r_txns, 32'd1);
    chk("post-flush dout", r_dout, 32'h13579BDF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
